data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Memory-side responder for the CPU core's data-SRAM port. It accepts one request at a time on the enable / byte-write-enable / address / write-data bus and serves it from an internal word array after a programmable latency. While the access is in flight it holds the core's memory-stage stall, then returns registered read data. It is the counterpart of the core's data-RAM initiator and is used in simulation and FPGA builds in place of the cached bus path.

## Interface
- AW, 10, word-address width; array depth = 2^AW 32-bit words
- LATENCY, 2, busy cycles per access; legal range 1..15

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  request valid (core memory-stage load/store)
- wen  in  4  byte write enables; wen[i] writes wdata[8i+7:8i]; 0000 = read
- addr  in  32  byte address; word index = addr[AW+1:2]
- wdata  in  32  store data, already byte-lane aligned by the core
- cancel  in  1  exception flush from the core; aborts an uncommitted access
- rdata  out  32  read data, registered
- stall  out  1  core must hold its memory stage while high
- done  out  1  one-cycle pulse marking the completion cycle

## Operation
- FSM states: IDLE, BUSY, DONE. A 4-bit down-counter `cnt` tracks the access.
- IDLE:
  - en=1 and cancel=0: latch addr, wen and wdata; load cnt=LATENCY; go to BUSY; stall=1 in this cycle (combinational).
  - en=0, or cancel=1: stay in IDLE; stall=0.
- BUSY:
  - stall=1; cnt decrements each cycle.
  - When cnt==1 and cancel=0, commit the access at the clock edge, then go to DONE.
  - Commit for a write (wen≠0): write only the enabled bytes of the latched word; rdata is unchanged.
  - Commit for a read (wen=0): rdata ← mem[latched index].
- DONE:
  - stall=0 and done=1; the core advances at the end of this cycle; go to IDLE.
  - en is still high in this cycle for the same request and is ignored, so no second access starts.
- Cancel:
  - cancel=1 in any BUSY cycle, including the cnt==1 cycle, has priority over commit.
  - No write occurs and rdata is unchanged.
  - stall=0 in that cycle; next state is IDLE.
  - cancel in DONE has no effect, because the access is already committed.
- Addressing:
  - addr[1:0] is ignored; alignment exceptions belong to the core.
  - addr[31:AW+2] is ignored, so addresses wrap modulo 2^AW words.
- Request fields change while BUSY: ignored; the latched copies are used.
- Array contents are not reset; the simulation initial value is 0.

## Timing
- Reset (async assert, sync release): state=IDLE, cnt=0, rdata=0, done=0. stall is forced to 0 while rst=1.
- Request accepted at cycle T:
  - stall is high in cycles T..T+LATENCY.
  - Commit happens at the edge ending cycle T+LATENCY.
  - DONE is cycle T+LATENCY+1, with stall=0, done=1 and rdata valid.
- Total occupancy: LATENCY+2 cycles per access.
- Back-to-back requests: the earliest next acceptance is cycle T+LATENCY+2 (IDLE). There is no bubble beyond the DONE cycle.
- Read-after-write to the same word: the read returns the merged bytes written by the earlier store.
- Reset asserted mid-BUSY: the FSM returns to IDLE immediately, with no commit. Array contents are left as last committed.

## Test plan
- Read, LATENCY=2: preload mem[5]=0xDEADBEEF; drive en=1, wen=0000, addr=0x14 at cycle T.
  - Required: stall=1 in T..T+2.
  - Required: in T+3, stall=0, done=1, rdata=0xDEADBEEF.
- Byte-lane write: mem[3]=0x11223344; store wen=0101, wdata=0xAABBCCDD to addr=0x0C, then read addr=0x0C.
  - Required: the read returns 0x11BB33DD.
  - Required: the second request is accepted in the cycle after DONE.
- Cancel on the commit cycle: store wen=1111, wdata=0xFFFFFFFF to addr=0x20 with mem[8]=0; raise cancel in the last BUSY cycle.
  - Required: stall=0 in that cycle, then IDLE, done never pulses.
  - Required: a later read of 0x20 returns 0.
- Cancel at request: en=1 and cancel=1 in IDLE.
  - Required: stall=0, the state stays IDLE, and no access occurs.
- Wrap and alignment, AW=10: write 0x12345678 to addr=0x00001003, then read addr=0x00000000.
  - Required: the read returns 0x12345678.
- Async reset mid-BUSY: assert rst between clock edges during a store.
  - Required: stall, done and rdata go to 0 without a clock edge.
  - Required: the target word is unchanged.
  - Required: after release, a new request completes with normal timing.

Source files
------------

// File: rtl/data_sram_responder.sv
`timescale 1ns/1ps
// Data-SRAM responder: serves one core load/store at a time from an internal
// word array after LATENCY busy cycles, holding the memory-stage stall meanwhile.
module data_sram_responder #(
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        cancel,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

    stateType      state;
    logic [3:0]    cnt;
    logic [AW-1:0] idxQ;
    logic [3:0]    wenQ;
    logic [31:0]   wdataQ;
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          accept;
    logic          commit;
    logic          unusedAddrBits;

    // Byte offset and bits above the array wrap are deliberately dropped.
    assign unusedAddrBits = ^{addr[31:AW+2], addr[1:0]};

    assign accept = (state == IDLE) && en && !cancel;
    assign commit = (state == BUSY) && (cnt == 4'd1) && !cancel;

    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = accept || ((state == BUSY) && !cancel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rdata  <= '0;
            done   <= 1'b0;
            idxQ   <= '0;
            wenQ   <= '0;
            wdataQ <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= BUSY;
                        cnt    <= 4'(LATENCY);
                        idxQ   <= addr[AW+1:2];
                        wenQ   <= wen;
                        wdataQ <= wdata;
                    end
                end
                BUSY: begin
                    if (cancel) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == 4'd1) begin
                        state <= DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                        if (wenQ == '0) begin
                            rdata <= mem[idxQ];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // en is still high here for the finished request; ignore it.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wenQ[i]) begin
                    mem[idxQ][8*i +: 8] <= wdataQ[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
`timescale 1ns/1ps
// Self-checking bench for data_sram_responder: directed scenarios plus a
// randomized run against a word-array reference model.
module tb_data_sram_responder;
    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cancel;
    logic [31:0] rdata;
    logic        stall;
    logic        done;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] refMem [DEPTH];
    logic [31:0] refRdata;

    data_sram_responder #(.AW(AW), .LATENCY(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .wen    (wen),
        .addr   (addr),
        .wdata  (wdata),
        .cancel (cancel),
        .rdata  (rdata),
        .stall  (stall),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic int wordOf(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(DEPTH));
    endfunction

    // Drives one request starting now (just after a rising edge, DUT idle) and
    // checks every cycle of it; cancelAt = 1..LAT raises cancel in that busy cycle.
    task automatic runAccess(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                             input int cancelAt, input string tag);
        int   idx     = wordOf(a);
        logic aborted = 1'b0;
        logic expDone;
        en = 1'b1; wen = w; addr = a; wdata = d; cancel = 1'b0;
        @(negedge clk);
        nCompared++;
        if (stall !== 1'b1 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s_accept: got stall=%b done=%b, want stall=1 done=0", tag, stall, done);
        end
        for (int c = 1; c <= LAT; c++) begin
            @(posedge clk); #1;
            wen = 4'($urandom); addr = $urandom; wdata = $urandom;
            cancel = (c == cancelAt);
            @(negedge clk);
            nCompared++;
            if (c == cancelAt) begin
                if (stall !== 1'b0 || done !== 1'b0) begin
                    nMismatched++;
                    $display("FAIL %s_cancel: got stall=%b done=%b, want stall=0 done=0", tag, stall, done);
                end
                aborted = 1'b1;
                break;
            end
            if (stall !== 1'b1 || done !== 1'b0) begin
                nMismatched++;
                $display("FAIL %s_busy%0d: got stall=%b done=%b, want stall=1 done=0", tag, c, stall, done);
            end
        end
        @(posedge clk); #1;
        if (aborted) begin
            en = 1'b0; cancel = 1'b0;
        end else begin
            cancel = 1'($urandom);
            for (int i = 0; i < 4; i++) if (w[i]) refMem[idx][8*i +: 8] = d[8*i +: 8];
            if (w == 4'b0000) refRdata = refMem[idx];
        end
        expDone = ~aborted;
        @(negedge clk);
        nCompared++;
        if (done !== expDone || stall !== 1'b0 || rdata !== refRdata) begin
            nMismatched++;
            $display("FAIL %s_done: got done=%b stall=%b rdata=%h, want done=%b stall=0 rdata=%h",
                     tag, done, stall, rdata, expDone, refRdata);
        end
        @(posedge clk); #1;
        en = 1'b0; cancel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; wen = '0; addr = '0; wdata = '0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        nCompared++;
        if (stall !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
            nMismatched++;
            $display("FAIL reset: got stall=%b done=%b rdata=%h, want 0 0 0", stall, done, rdata);
        end
        rst = 1'b0; en = 1'b0;
        refRdata = '0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_warmup();
        for (int i = 0; i < 32; i++) runAccess(4'hF, 32'(i * 4), $urandom, 0, "warm");
    endtask

    task automatic test_read();
        runAccess(4'hF, 32'h14, 32'hDEADBEEF, 0, "rd_pre");
        runAccess(4'h0, 32'h14, 32'h0, 0, "rd");
        nCompared++;
        if (rdata !== 32'hDEADBEEF) begin
            nMismatched++;
            $display("FAIL read_value: got %h, want deadbeef", rdata);
        end
    endtask

    task automatic test_byte_lane();
        runAccess(4'hF, 32'h0C, 32'h11223344, 0, "bl_pre");
        runAccess(4'b0101, 32'h0C, 32'hAABBCCDD, 0, "bl_wr");
        runAccess(4'h0, 32'h0C, 32'h0, 0, "bl_rd");
        nCompared++;
        if (rdata !== 32'h11BB33DD) begin
            nMismatched++;
            $display("FAIL byte_lane: got %h, want 11bb33dd", rdata);
        end
    endtask

    task automatic test_cancel_commit();
        runAccess(4'hF, 32'h20, 32'h0, 0, "cc_pre");
        runAccess(4'hF, 32'h20, 32'hFFFFFFFF, LAT, "cc_wr");
        runAccess(4'h0, 32'h20, 32'h0, 0, "cc_rd");
        nCompared++;
        if (rdata !== 32'h0) begin
            nMismatched++;
            $display("FAIL cancel_commit: got %h, want 00000000", rdata);
        end
    endtask

    task automatic test_cancel_request();
        en = 1'b1; cancel = 1'b1; wen = 4'hF; addr = 32'h24; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        nCompared++;
        if (stall !== 1'b0) begin
            nMismatched++;
            $display("FAIL cancel_req_stall: got %b, want 0", stall);
        end
        @(posedge clk); #1;
        en = 1'b0; cancel = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            nCompared++;
            if (done !== 1'b0 || stall !== 1'b0) begin
                nMismatched++;
                $display("FAIL cancel_req_idle%0d: got done=%b stall=%b, want 0 0", c, done, stall);
            end
            @(posedge clk); #1;
        end
        runAccess(4'h0, 32'h24, 32'h0, 0, "cancel_req_rd");
    endtask

    task automatic test_wrap();
        runAccess(4'hF, 32'h00001003, 32'h12345678, 0, "wrap_wr");
        runAccess(4'h0, 32'h00000000, 32'h0, 0, "wrap_rd");
        nCompared++;
        if (rdata !== 32'h12345678) begin
            nMismatched++;
            $display("FAIL wrap: got %h, want 12345678", rdata);
        end
    endtask

    task automatic test_async_reset();
        runAccess(4'hF, 32'h40, 32'hCAFEF00D, 0, "ar_pre");
        runAccess(4'h0, 32'h40, 32'h0, 0, "ar_rd0");
        en = 1'b1; wen = 4'hF; addr = 32'h40; wdata = 32'h0BADBEEF; cancel = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        nCompared++;
        if (stall !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
            nMismatched++;
            $display("FAIL async_reset: got stall=%b done=%b rdata=%h, want 0 0 0", stall, done, rdata);
        end
        en = 1'b0;
        refRdata = '0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        runAccess(4'h0, 32'h40, 32'h0, 0, "ar_rd1");
        nCompared++;
        if (rdata !== 32'hCAFEF00D) begin
            nMismatched++;
            $display("FAIL async_reset_word: got %h, want cafef00d", rdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [3:0]  w;
            logic [31:0] a;
            int          ca;
            w  = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
            a  = ($urandom << 12) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : 0;
            runAccess(w, a, $urandom, ca, "rand");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_warmup();
        test_read();
        test_byte_lane();
        test_cancel_commit();
        test_cancel_request();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
